// File: rtl/hazard_stall_controller.sv
// Decode-stage hazard sequencer: detects load-use and decode-resolved branch/jr
// hazards, stalls PC and IF/ID, bubbles ID/EX, flushes IF/ID, with watchdog and event counters.
module hazard_stall_controller #(
    parameter int MAX_STALL = 4,
    parameter int CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             UsesRt_id,
    input  logic             Branch_id,
    input  logic             JumpReg_id,
    input  logic             Taken_id,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_RegWrite,
    input  logic [4:0]       IDEX_Rd,
    input  logic             EXMEM_MemRead,
    input  logic [4:0]       EXMEM_Rd,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic             HazardError,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic [1:0] {RUN, STALL, ERROR} state_t;

    localparam logic [3:0] MAX_RUN = 4'(MAX_STALL);

    state_t     state_q, state_d;
    logic [1:0] stall_left_q, stall_left_d;
    logic [3:0] run_len_q, run_len_d;

    logic       dec, ex_hit, mem_hit;
    logic       need2, need1;
    logic       stall, flush;

    // Register 0 is hardwired, so it can never carry a dependency.
    assign dec     = Branch_id | JumpReg_id;
    assign ex_hit  = (IDEX_Rd != 5'd0) &&
                     ((IDEX_Rd == rs_id) || (UsesRt_id && (IDEX_Rd == rt_id)));
    assign mem_hit = (EXMEM_Rd != 5'd0) &&
                     ((EXMEM_Rd == rs_id) || (UsesRt_id && (EXMEM_Rd == rt_id)));

    assign need2 = IDEX_MemRead && ex_hit && dec;
    assign need1 = (IDEX_MemRead && ex_hit && !dec) ||
                   (dec && IDEX_RegWrite && !IDEX_MemRead && ex_hit) ||
                   (dec && EXMEM_MemRead && mem_hit);

    assign stall = ((state_q == RUN) && (need2 || need1)) || (state_q == STALL);
    assign flush = Taken_id && !stall;

    assign PCWrite     = Reset && !stall;
    assign IFIDWrite   = Reset && !stall;
    assign IDEX_Bubble = !Reset || stall;
    assign IFID_Flush  = Reset && flush;
    assign HazardError = (state_q == ERROR);

    always_comb begin
        state_d      = state_q;
        stall_left_d = stall_left_q;
        run_len_d    = stall ? ((run_len_q == 4'hF) ? run_len_q : run_len_q + 4'd1) : 4'd0;

        case (state_q)
            RUN: begin
                if (need2) begin
                    state_d      = STALL;
                    stall_left_d = 2'd1;
                end
            end
            STALL: begin
                stall_left_d = stall_left_q - 2'd1;
                if (stall_left_q <= 2'd1) begin
                    state_d      = RUN;
                    stall_left_d = 2'd0;
                end
            end
            ERROR: begin
                run_len_d = 4'd0;
            end
            default: begin
                state_d      = RUN;
                stall_left_d = 2'd0;
            end
        endcase

        // Watchdog: a stall arriving after MAX_STALL consecutive stalls is one too many.
        if (stall && (run_len_q == MAX_RUN)) begin
            state_d      = ERROR;
            stall_left_d = 2'd0;
            run_len_d    = 4'd0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= RUN;
            stall_left_q <= 2'd0;
            run_len_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            stall_left_q <= stall_left_d;
            run_len_q    <= run_len_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (stall && !(&StallCount)) StallCount <= StallCount + 1'b1;
            if (flush && !(&FlushCount)) FlushCount <= FlushCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench: directed hazard scenarios then randomized traffic against a cycle-level model.
module tb_hazard_stall_controller;

    localparam int MAX_STALL = 4;
    localparam int CNT_W     = 16;
    localparam int CMAX      = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [4:0]       rs, rt, rd, erd;
    logic             ur, br, jr, tk, mr, rw, emr;
    logic             PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, HazardError;
    logic [CNT_W-1:0] StallCount, FlushCount;

    int n_chk = 0;
    int n_err = 0;

    // model state: pending forced stall cycles, consecutive stalls, sticky error, counters
    int m_forced, m_run, m_sc, m_fc;
    bit m_err;

    always #5 Clk = ~Clk;

    hazard_stall_controller #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .rs_id(rs), .rt_id(rt), .UsesRt_id(ur),
        .Branch_id(br), .JumpReg_id(jr), .Taken_id(tk),
        .IDEX_MemRead(mr), .IDEX_RegWrite(rw), .IDEX_Rd(rd),
        .EXMEM_MemRead(emr), .EXMEM_Rd(erd),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEX_Bubble(IDEX_Bubble),
        .IFID_Flush(IFID_Flush), .HazardError(HazardError),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int need();
        bit dec, eh, mh;
        dec = br | jr;
        eh  = (rd != 0) && (rd == rs || (ur && rd == rt));
        mh  = (erd != 0) && (erd == rs || (ur && erd == rt));
        if (mr && eh && dec) return 2;
        if ((mr && eh) || (dec && rw && !mr && eh) || (dec && emr && mh)) return 1;
        return 0;
    endfunction

    task automatic clr();
        Reset = 1'b1;
        rs = 0; rt = 0; rd = 0; erd = 0;
        ur = 0; br = 0; jr = 0; tk = 0; mr = 0; rw = 0; emr = 0;
    endtask

    // Inputs are set by the caller; check mid-cycle, then advance the model on the edge.
    task automatic step(input string tag);
        int  n;
        bit  st, e_fl;
        @(negedge Clk);
        if (!Reset) begin
            m_forced = 0; m_run = 0; m_sc = 0; m_fc = 0; m_err = 0;
        end
        n    = need();
        st   = Reset && !m_err && (m_forced > 0 || n > 0);
        e_fl = Reset && tk && !st;
        chk({tag, ".pcw"},   32'(PCWrite),     32'(Reset && !st));
        chk({tag, ".ifidw"}, 32'(IFIDWrite),   32'(Reset && !st));
        chk({tag, ".bub"},   32'(IDEX_Bubble), 32'(!Reset || st));
        chk({tag, ".flush"}, 32'(IFID_Flush),  32'(e_fl));
        chk({tag, ".herr"},  32'(HazardError), 32'(m_err));
        chk({tag, ".scnt"},  32'(StallCount),  32'(m_sc));
        chk({tag, ".fcnt"},  32'(FlushCount),  32'(m_fc));
        @(posedge Clk);
        if (Reset) begin
            if (st && m_sc < CMAX) m_sc++;
            if (e_fl && m_fc < CMAX) m_fc++;
            if (!m_err) begin
                if (st && m_run == MAX_STALL) begin
                    m_err = 1; m_forced = 0; m_run = 0;
                end else begin
                    m_run = st ? m_run + 1 : 0;
                    if (m_forced > 0) m_forced--;
                    else if (st && n == 2) m_forced = 1;
                end
            end
        end
        #1;
    endtask

    initial begin
        clr();
        Reset = 1'b0;
        step("rst");
        step("rst2");
        clr();
        step("idle");

        // load-use on rs: single stall
        mr = 1; rw = 1; rd = 8; rs = 8;
        step("lu");
        clr();
        step("lu_after");
        chk("lu_scnt", 32'(StallCount), 32'd1);

        // load feeding a decode branch: two stalls, then flush
        mr = 1; rw = 1; rd = 8; rs = 8; br = 1; tk = 1;
        step("lbr0");
        step("lbr1");
        mr = 0; rw = 0; rd = 0;
        step("lbr_flush");
        clr();
        step("lbr_after");
        chk("lbr_scnt", 32'(StallCount), 32'd3);
        chk("lbr_fcnt", 32'(FlushCount), 32'd1);

        // ALU result feeding jr: one stall, then taken jump flushes
        rw = 1; rd = 9; rs = 9; jr = 1;
        step("jr_stall");
        rw = 0; rd = 0; tk = 1;
        step("jr_flush");
        clr();
        step("jr_after");
        chk("jr_fcnt", 32'(FlushCount), 32'd2);

        // load-use via EX/MEM into a branch
        emr = 1; erd = 5; rt = 5; ur = 1; br = 1;
        step("memld_br");
        clr();

        // register 0 and unused rt never match
        mr = 1; rd = 0; rs = 0;
        step("r0");
        rd = 8; rs = 1; rt = 8; ur = 0;
        step("nort");
        clr();

        // held hazard trips the watchdog; error is sticky
        mr = 1; rw = 1; rd = 8; rs = 8;
        for (int i = 0; i < 7; i++) step("wdog");
        chk("wdog_herr", 32'(HazardError), 32'd1);
        chk("wdog_pcw",  32'(PCWrite), 32'd1);
        clr();
        step("wdog_hold");

        // reset in the middle of a two-cycle stall
        Reset = 0;
        step("rst_err");
        clr();
        mr = 1; rw = 1; rd = 8; rs = 8; br = 1;
        step("mid0");
        Reset = 0;
        step("mid_rst");
        chk("mid_scnt", 32'(StallCount), 32'd0);
        clr();
        step("mid_rel");

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int   pick;
            logic [4:0] pool [4];
            pool[0] = 5'd0; pool[1] = 5'd8; pool[2] = 5'd9;
            pool[3] = 5'($urandom_range(0, 31));
            Reset = ($urandom_range(0, 39) != 0);
            pick = $urandom_range(0, 3); rs  = pool[pick];
            pick = $urandom_range(0, 3); rt  = pool[pick];
            pick = $urandom_range(0, 3); rd  = pool[pick];
            pick = $urandom_range(0, 3); erd = pool[pick];
            ur  = 1'($urandom_range(0, 1));
            br  = ($urandom_range(0, 3) == 0);
            jr  = ($urandom_range(0, 5) == 0);
            tk  = ($urandom_range(0, 2) == 0);
            mr  = ($urandom_range(0, 2) == 0);
            rw  = 1'($urandom_range(0, 1));
            emr = ($urandom_range(0, 3) == 0);
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
